// File: rtl/fphub_sqrt_param.sv
// Iterative square root for HUB floating-point operands: radix-2 restoring
// recurrence producing one root bit per cycle, with early bypass of special operands.
//
// state | meaning
// IDLE  | waiting for start; operand captured on the accepting edge
// LOAD  | classify operand; specials go straight to DONE, normals build radicand
// CALC  | MAN_W+1 recurrence cycles, computing=1
// DONE  | single cycle, finish=1, res/invalid valid
module fphub_sqrt_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 2**(EXP_W-1)-1,
    localparam int W    = 1+EXP_W+MAN_W
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         start,
    input  logic [W-1:0] x,
    output logic [W-1:0] res,
    output logic         finish,
    output logic         computing,
    output logic         invalid
);

    localparam int CNT_W = $clog2(MAN_W+1);
    localparam logic [EXP_W:0] BIAS_U = (EXP_W+1)'(BIAS);
    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t             state_q;
    logic [W-1:0]       x_q;
    logic [2*MAN_W+1:0] rad_q;
    logic [MAN_W+3:0]   rem_q;
    logic [MAN_W:0]     q_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [EXP_W-1:0]   exp_q;
    logic [W-1:0]       res_q;
    logic               fin_q;
    logic               comp_q;
    logic               inv_q;

    logic               sign_w;
    logic [EXP_W-1:0]   exp_w;
    logic [MAN_W-1:0]   man_w;
    logic [EXP_W:0]     exp_sum;
    logic               exp_zero;
    logic               exp_ones;
    logic               special;
    logic [W-1:0]       spec_res;
    logic               spec_inv;
    logic [MAN_W+1:0]   s_w;
    logic [2*MAN_W+1:0] rad_full;
    logic [2*MAN_W+1:0] rad_d;
    logic [MAN_W+3:0]   trial;
    logic [MAN_W+3:0]   dval;
    logic [MAN_W+3:0]   rem_d;
    logic [MAN_W:0]     q_d;

    always_comb begin
        sign_w   = x_q[W-1];
        exp_w    = x_q[W-2 -: EXP_W];
        man_w    = x_q[MAN_W-1:0];
        exp_zero = (exp_w == '0);
        exp_ones = (exp_w == {EXP_W{1'b1}});
        special  = exp_zero | exp_ones | sign_w;

        spec_res = CANON_NAN;
        spec_inv = 1'b1;
        if (exp_zero) begin
            spec_res = {sign_w, {(W-1){1'b0}}};
            spec_inv = 1'b0;
        end else if (exp_ones && (man_w == '0) && !sign_w) begin
            spec_res = x_q;
            spec_inv = 1'b0;
        end

        // floor((exp-BIAS)/2)+BIAS == floor((exp+BIAS)/2); bit 0 is the parity of exp-BIAS
        exp_sum  = {1'b0, exp_w} + BIAS_U;

        // Radicand 1.man plus ILSB, scaled so the integer root has MAN_W fraction bits
        s_w      = {1'b1, man_w, 1'b1};
        rad_full = {s_w, {MAN_W{1'b0}}};
        rad_d    = exp_sum[0] ? rad_full : (rad_full >> 1);

        trial = (rem_q << 2) | {{(MAN_W+2){1'b0}}, rad_q[2*MAN_W+1 -: 2]};
        dval  = {1'b0, q_q, 2'b01};
        if (trial >= dval) begin
            rem_d = trial - dval;
            q_d   = {q_q[MAN_W-1:0], 1'b1};
        end else begin
            rem_d = trial;
            q_d   = {q_q[MAN_W-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= IDLE;
            x_q     <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
            fin_q   <= 1'b0;
            comp_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (special) begin
                        res_q   <= spec_res;
                        inv_q   <= spec_inv;
                        fin_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rad_q   <= rad_d;
                        rem_q   <= '0;
                        q_q     <= '0;
                        exp_q   <= exp_sum[EXP_W:1];
                        cnt_q   <= CNT_W'(MAN_W);
                        comp_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rad_q <= rad_q << 2;
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        res_q   <= {1'b0, exp_q, q_d[MAN_W-1:0]};
                        inv_q   <= 1'b0;
                        fin_q   <= 1'b1;
                        comp_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign res       = res_q;
    assign finish    = fin_q;
    assign computing = comp_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_fphub_sqrt_param.sv
// Bench for fphub_sqrt_param: default 32-bit and 16-bit instances, vector tables,
// scoreboard of expected results, random sweep against an integer-sqrt reference.
module tb_fphub_sqrt_param;

    typedef struct {
        logic [31:0] x;
        logic [31:0] res;
        logic        inv;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        int          lat;
        int          comp;
        int          acc;
    } sbe_t;

    logic        clk;
    logic        rst_l;
    logic        start32, start16;
    logic [31:0] x32, res32;
    logic [15:0] x16, res16;
    logic        finish32, computing32, invalid32;
    logic        finish16, computing16, invalid16;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   comp32 = 0, comp16 = 0;
    int   nfin32 = 0, nfin16 = 0;
    sbe_t sb32[$];
    sbe_t sb16[$];

    fphub_sqrt_param dut32 (
        .clk(clk), .rst_l(rst_l), .start(start32), .x(x32),
        .res(res32), .finish(finish32), .computing(computing32), .invalid(invalid32)
    );

    fphub_sqrt_param #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_l(rst_l), .start(start16), .x(x16),
        .res(res16), .finish(finish16), .computing(computing16), .invalid(invalid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event occurred, expected it not to", nm);
    endtask

    // Reference: largest q with q*q <= radicand, found by binary search
    function automatic sbe_t model(input logic [31:0] xin, input int ew, input int mw);
        sbe_t   e;
        longint one, xv, sign, ex, man, bias, emax, nan, ev, s, r, lo, hi, mid;
        one  = 1;
        xv   = longint'({32'd0, xin});
        sign = (xv >> (ew + mw)) & one;
        ex   = (xv >> mw) & ((one << ew) - 1);
        man  = xv & ((one << mw) - 1);
        bias = (one << (ew - 1)) - 1;
        emax = (one << ew) - 1;
        nan  = (emax << mw) | (one << (mw - 1));
        e.acc = 0;
        e.lat = 1;
        e.comp = 0;
        e.inv = 1'b0;
        if (ex == 0) begin
            e.res = 32'(sign << (ew + mw));
        end else if (ex == emax && man != 0) begin
            e.res = 32'(nan);
            e.inv = 1'b1;
        end else if (sign != 0) begin
            e.res = 32'(nan);
            e.inv = 1'b1;
        end else if (ex == emax) begin
            e.res = xin;
        end else begin
            ev = ex - bias;
            s  = (one << (mw + 1)) | (man << 1) | one;
            if (ev % 2 != 0) begin
                s  = s * 2;
                ev = ev - 1;
            end
            r  = s << (mw - 1);
            lo = 0;
            hi = one << (mw + 1);
            while (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if (mid * mid <= r) lo = mid;
                else hi = mid - 1;
            end
            e.res  = 32'(((ev / 2 + bias) << mw) | (lo & ((one << mw) - 1)));
            e.lat  = mw + 2;
            e.comp = mw + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        sbe_t e;
        if (!rst_l) comp32 = 0;
        else begin
            if (computing32) comp32++;
            if (finish32) begin
                check("excl32", {63'd0, computing32}, 64'd0);
                if (sb32.size() == 0) fail("unexpected_finish32");
                else begin
                    e = sb32.pop_front();
                    check("res32", {32'd0, res32}, {32'd0, e.res});
                    check("inv32", {63'd0, invalid32}, {63'd0, e.inv});
                    check("lat32", 64'(cyc - e.acc), 64'(e.lat));
                    check("comp32", 64'(comp32), 64'(e.comp));
                end
                comp32 = 0;
                nfin32++;
            end
        end
    end

    always @(negedge clk) begin
        sbe_t e;
        if (!rst_l) comp16 = 0;
        else begin
            if (computing16) comp16++;
            if (finish16) begin
                check("excl16", {63'd0, computing16}, 64'd0);
                if (sb16.size() == 0) fail("unexpected_finish16");
                else begin
                    e = sb16.pop_front();
                    check("res16", {48'd0, res16}, {32'd0, e.res});
                    check("inv16", {63'd0, invalid16}, {63'd0, e.inv});
                    check("lat16", 64'(cyc - e.acc), 64'(e.lat));
                    check("comp16", 64'(comp16), 64'(e.comp));
                end
                comp16 = 0;
                nfin16++;
            end
        end
    end

    task automatic wait_done(input bit w16);
        int n = 0;
        while (((w16 ? sb16.size() : sb32.size()) != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check(w16 ? "timeout16" : "timeout32", 64'(n), 64'd0);
            if (w16) sb16.delete();
            else sb32.delete();
        end
    endtask

    task automatic op(input bit w16, input logic [31:0] xv, input sbe_t e);
        @(negedge clk);
        if (w16) begin x16 = xv[15:0]; start16 = 1'b1; end
        else begin x32 = xv; start32 = 1'b1; end
        @(posedge clk);
        #1;
        start16 = 1'b0;
        start32 = 1'b0;
        e.acc = cyc;
        if (w16) sb16.push_back(e);
        else sb32.push_back(e);
        wait_done(w16);
    endtask

    function automatic sbe_t from_vec(input vec_t v);
        sbe_t e;
        e.res  = v.res;
        e.inv  = v.inv;
        e.lat  = v.lat;
        e.comp = (v.lat > 1) ? v.lat - 1 : 0;
        e.acc  = 0;
        return e;
    endfunction

    initial begin
        vec_t        t32[10];
        vec_t        t16[4];
        sbe_t        e;
        logic [31:0] xv;
        int          base;

        t32[0] = '{32'h40000000, 32'h3FB504F3, 1'b0, 25};
        t32[1] = '{32'h40800000, 32'h40000000, 1'b0, 25};
        t32[2] = '{32'h3F800000, 32'h3F800000, 1'b0, 25};
        t32[3] = '{32'h40400000, 32'h3FDDB3D7, 1'b0, 25};
        t32[4] = '{32'hC0800000, 32'h7FC00000, 1'b1, 1};
        t32[5] = '{32'h00000000, 32'h00000000, 1'b0, 1};
        t32[6] = '{32'h80000000, 32'h80000000, 1'b0, 1};
        t32[7] = '{32'h7F800000, 32'h7F800000, 1'b0, 1};
        t32[8] = '{32'h7F800001, 32'h7FC00000, 1'b1, 1};
        t32[9] = '{32'hFF800000, 32'h7FC00000, 1'b1, 1};
        t16[0] = '{32'h4000, 32'h3DA8, 1'b0, 12};
        t16[1] = '{32'h3C00, 32'h3C00, 1'b0, 12};
        t16[2] = '{32'h4400, 32'h4000, 1'b0, 12};
        t16[3] = '{32'hC400, 32'h7E00, 1'b1, 1};

        rst_l = 1'b0; start32 = 1'b0; start16 = 1'b0; x32 = '0; x16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res32", {32'd0, res32}, 64'd0);
        check("rst_fin32", {63'd0, finish32}, 64'd0);
        check("rst_comp32", {63'd0, computing32}, 64'd0);
        check("rst_inv32", {63'd0, invalid32}, 64'd0);
        check("rst_res16", {48'd0, res16}, 64'd0);
        #1 rst_l = 1'b1;

        for (int i = 0; i < 10; i++) op(1'b0, t32[i].x, from_vec(t32[i]));
        for (int i = 0; i < 4; i++) op(1'b1, t16[i].x, from_vec(t16[i]));

        for (int i = 0; i < 24; i++) begin
            xv = $urandom;
            if (i % 4 != 3) begin
                xv[31] = 1'b0;
                xv[30:23] = 8'($urandom_range(1, 254));
            end
            op(1'b0, xv, model(xv, 8, 23));
        end
        for (int i = 0; i < 24; i++) begin
            xv = {16'd0, 16'($urandom)};
            if (i % 4 != 3) begin
                xv[15] = 1'b0;
                xv[14:10] = 5'($urandom_range(1, 30));
            end
            op(1'b1, xv, model(xv, 5, 10));
        end

        // start held high: accepted, ignored through LOAD/DONE, re-accepted after DONE
        @(negedge clk);
        x32 = 32'h80000000; start32 = 1'b1;
        @(posedge clk); #1;
        e = model(32'h80000000, 8, 23); e.acc = cyc; sb32.push_back(e);
        repeat (3) @(posedge clk); #1;
        e.acc = cyc; sb32.push_back(e);
        start32 = 1'b0;
        wait_done(1'b0);

        // second start during CALC must be ignored
        base = nfin32;
        @(negedge clk);
        x32 = 32'h40000000; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        e = from_vec(t32[0]); e.acc = cyc; sb32.push_back(e);
        repeat (4) @(negedge clk);
        x32 = 32'h40800000; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait_done(1'b0);
        repeat (30) @(negedge clk);
        check("ignored_start_finishes", 64'(nfin32 - base), 64'd1);

        // reset mid-operation discards the operation
        op(1'b0, 32'hC0800000, from_vec(t32[4]));
        @(negedge clk);
        x32 = 32'h40000000; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_l = 1'b0;
        @(posedge clk); #1;
        check("abort_comp", {63'd0, computing32}, 64'd0);
        check("abort_res", {32'd0, res32}, 64'd0);
        check("abort_fin", {63'd0, finish32}, 64'd0);
        check("abort_inv", {63'd0, invalid32}, 64'd0);
        #1 rst_l = 1'b1;
        base = nfin32;
        repeat (40) @(negedge clk);
        check("abort_no_finish", 64'(nfin32 - base), 64'd0);
        op(1'b0, 32'h3F800000, from_vec(t32[2]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
